// File: rtl/data_mem_bridge.sv
// data_mem_bridge
//
// Purpose:
//   Connects the CPU core's single-cycle data-RAM port to a data memory or bus
//   slave whose latency varies. The slave uses a req/ack handshake. Only one
//   access is in flight at a time. The CPU is held on cpu_stall until that
//   access completes, and read data comes back on a register.
//
//   If the slave does not acknowledge within TIMEOUT cycles, the access is
//   aborted. The sticky bus_err flag is then set, and a read returns ERR_DATA.
//
// Optional feature (macro DATA_MEM_BRIDGE_WBUF_EN):
//   Adds a one-entry posted write buffer. A write is accepted without stalling
//   and completes in the background. Its completion returns straight to IDLE.
//   Any new access presented while that write is outstanding is stalled.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous reset, active low
//   cpu_ena    in   1   CPU access request this cycle
//   cpu_wea    in   4   byte write strobes, 0 = read
//   cpu_addr   in  32   byte address
//   cpu_wdata  in  32   write data
//   cpu_rdata  out 32   registered read data
//   cpu_stall  out  1   stall request to the CPU hazard logic
//   bus_err    out  1   sticky timeout flag
//   mem_req    out  1   request to the slave
//   mem_wr     out  1   1 = write
//   mem_wstrb  out  4   byte strobes
//   mem_addr   out 32   word-aligned address
//   mem_wdata  out 32   write data
//   mem_ack    in   1   slave completion pulse
//   mem_rdata  in  32   slave read data, valid with mem_ack

module data_mem_bridge #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ena,
  input  logic [3:0]  cpu_wea,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // The counter holds the number of WAIT cycles already spent. When it reaches
  // TIMEOUT-1 with no ack, mem_req has been high for exactly TIMEOUT cycles.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        req_q, req_d;
  logic        wr_q, wr_d;
  logic [3:0]  strb_q, strb_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        accept_stall;
  logic        wait_stall;
  logic        finish_to_idle;

  // The slave is addressed by word, so the byte offset is never forwarded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^cpu_addr[1:0];

`ifdef DATA_MEM_BRIDGE_WBUF_EN
  logic posted_q, posted_d;

  // A write is posted and does not stall on accept. While a posted write is
  // outstanding, the CPU is free to run and stalls only if it presents
  // another access.
  assign accept_stall   = cpu_ena && (cpu_wea == 4'h0);
  assign wait_stall     = posted_q ? cpu_ena : 1'b1;
  assign finish_to_idle = posted_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) posted_q <= 1'b0;
    else      posted_q <= posted_d;
  end
`else
  assign accept_stall   = cpu_ena;
  assign wait_stall     = 1'b1;
  assign finish_to_idle = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      strb_q  <= 4'h0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      req_q   <= req_d;
      wr_q    <= wr_d;
      strb_q  <= strb_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    req_d     = req_q;
    wr_d      = wr_q;
    strb_d    = strb_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cpu_stall = 1'b0;
`ifdef DATA_MEM_BRIDGE_WBUF_EN
    posted_d  = posted_q;
`endif

    case (state_q)
      ST_IDLE: begin
        cpu_stall = accept_stall;
        if (cpu_ena) begin
          req_d   = 1'b1;
          wr_d    = |cpu_wea;
          strb_d  = cpu_wea;
          addr_d  = {cpu_addr[31:2], 2'b00};
          wdata_d = cpu_wdata;
          cnt_d   = 8'd0;
          state_d = ST_WAIT;
`ifdef DATA_MEM_BRIDGE_WBUF_EN
          posted_d = |cpu_wea;
`endif
        end
      end

      ST_WAIT: begin
        cpu_stall = wait_stall;
        if (mem_ack || (cnt_q == CNT_LAST)) begin
          req_d   = 1'b0;
          cnt_d   = 8'd0;
          state_d = finish_to_idle ? ST_IDLE : ST_DONE;
`ifdef DATA_MEM_BRIDGE_WBUF_EN
          posted_d = 1'b0;
`endif
          // An ack in the final counted cycle still wins over the timeout.
          if (mem_ack) begin
            if (!wr_q) rdata_d = mem_rdata;
          end else begin
            err_d = 1'b1;
            if (!wr_q) rdata_d = ERR_DATA;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      // The CPU is still presenting the request that just completed, so
      // cpu_ena is deliberately ignored here.
      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign cpu_rdata = rdata_q;
  assign bus_err   = err_q;
  assign mem_req   = req_q;
  assign mem_wr    = wr_q;
  assign mem_wstrb = strb_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_data_mem_bridge.sv
// Directed testbench for data_mem_bridge, built with TIMEOUT=4.
// Inputs are driven 1ns after the rising edge and outputs are sampled 1ns
// later, well before the next edge.

module tb_data_mem_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_ena = 1'b0;
  logic [3:0]  cpu_wea = 4'h0;
  logic [31:0] cpu_addr = 32'd0;
  logic [31:0] cpu_wdata = 32'd0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        bus_err;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  int nChecks = 0;
  int nFails  = 0;

  data_mem_bridge #(
    .TIMEOUT(4),
    .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cpu_ena(cpu_ena),
    .cpu_wea(cpu_wea),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .bus_err(bus_err),
    .mem_req(mem_req),
    .mem_wr(mem_wr),
    .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  // 10ns clock period.
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to 1ns past the next rising edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Reset values and the combinational stall path while in reset.
  task automatic test_reset();
    rst = 1'b0;
    cpu_ena = 1'b0;
    #2;
    nChecks++; if (mem_req !== 1'b0) begin nFails++; $display("[TB] FAIL reset_mem_req: got %0h want 0", mem_req); end
    nChecks++; if (mem_wr !== 1'b0) begin nFails++; $display("[TB] FAIL reset_mem_wr: got %0h want 0", mem_wr); end
    nChecks++; if (mem_wstrb !== 4'h0) begin nFails++; $display("[TB] FAIL reset_mem_wstrb: got %0h want 0", mem_wstrb); end
    nChecks++; if (mem_addr !== 32'd0) begin nFails++; $display("[TB] FAIL reset_mem_addr: got %h want 0", mem_addr); end
    nChecks++; if (mem_wdata !== 32'd0) begin nFails++; $display("[TB] FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
    nChecks++; if (cpu_rdata !== 32'd0) begin nFails++; $display("[TB] FAIL reset_cpu_rdata: got %h want 0", cpu_rdata); end
    nChecks++; if (bus_err !== 1'b0) begin nFails++; $display("[TB] FAIL reset_bus_err: got %0h want 0", bus_err); end
    nChecks++; if (cpu_stall !== 1'b0) begin nFails++; $display("[TB] FAIL reset_stall_idle: got %0h want 0", cpu_stall); end
    cpu_ena = 1'b1;
    #1;
    nChecks++; if (cpu_stall !== 1'b1) begin nFails++; $display("[TB] FAIL reset_stall_follows_ena: got %0h want 1", cpu_stall); end
    cpu_ena = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    nextCycle();
  endtask

  // Read at 0x10, acked 2 cycles after mem_req: 4 stall cycles, then DONE.
  task automatic test_read();
    int stallCnt;
    stallCnt = 0;
    cpu_ena = 1'b1; cpu_wea = 4'h0; cpu_addr = 32'h0000_0010; cpu_wdata = 32'h0;
    #1;
    stallCnt += int'(cpu_stall);
    nChecks++; if (mem_req !== 1'b0) begin nFails++; $display("[TB] FAIL read_req_capture: got %0h want 0", mem_req); end
    nextCycle();
    #1;
    stallCnt += int'(cpu_stall);
    nChecks++; if (mem_req !== 1'b1) begin nFails++; $display("[TB] FAIL read_req_wait: got %0h want 1", mem_req); end
    nChecks++; if (mem_addr !== 32'h0000_0010) begin nFails++; $display("[TB] FAIL read_mem_addr: got %h want 00000010", mem_addr); end
    nChecks++; if (mem_wr !== 1'b0) begin nFails++; $display("[TB] FAIL read_mem_wr: got %0h want 0", mem_wr); end
    nextCycle();
    #1;
    stallCnt += int'(cpu_stall);
    nChecks++; if (mem_req !== 1'b1) begin nFails++; $display("[TB] FAIL read_req_held: got %0h want 1", mem_req); end
    nextCycle();
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    #1;
    stallCnt += int'(cpu_stall);
    nextCycle();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    #1;
    nChecks++; if (cpu_stall !== 1'b0) begin nFails++; $display("[TB] FAIL read_done_stall: got %0h want 0", cpu_stall); end
    nChecks++; if (cpu_rdata !== 32'h1234_5678) begin nFails++; $display("[TB] FAIL read_rdata: got %h want 12345678", cpu_rdata); end
    nChecks++; if (mem_req !== 1'b0) begin nFails++; $display("[TB] FAIL read_req_done: got %0h want 0", mem_req); end
    nChecks++; if (stallCnt !== 4) begin nFails++; $display("[TB] FAIL read_stall_cycles: got %0d want 4", stallCnt); end
    cpu_ena = 1'b0;
    nextCycle();
  endtask

  // Write, acked in the first request cycle. Read data must not change.
  task automatic test_write();
    int stallCnt;
    stallCnt = 0;
    cpu_ena = 1'b1; cpu_wea = 4'b0011; cpu_addr = 32'h0000_0023; cpu_wdata = 32'hAABB_CCDD;
    #1;
    stallCnt += int'(cpu_stall);
    nextCycle();
`ifdef DATA_MEM_BRIDGE_WBUF_EN
    cpu_ena = 1'b0;
`endif
    mem_ack = 1'b1;
    #1;
    stallCnt += int'(cpu_stall);
    nChecks++; if (mem_req !== 1'b1) begin nFails++; $display("[TB] FAIL write_req: got %0h want 1", mem_req); end
    nChecks++; if (mem_wr !== 1'b1) begin nFails++; $display("[TB] FAIL write_mem_wr: got %0h want 1", mem_wr); end
    nChecks++; if (mem_addr !== 32'h0000_0020) begin nFails++; $display("[TB] FAIL write_mem_addr: got %h want 00000020", mem_addr); end
    nChecks++; if (mem_wstrb !== 4'b0011) begin nFails++; $display("[TB] FAIL write_mem_wstrb: got %0h want 3", mem_wstrb); end
    nChecks++; if (mem_wdata !== 32'hAABB_CCDD) begin nFails++; $display("[TB] FAIL write_mem_wdata: got %h want aabbccdd", mem_wdata); end
    nextCycle();
    mem_ack = 1'b0;
    #1;
    nChecks++; if (cpu_stall !== 1'b0) begin nFails++; $display("[TB] FAIL write_done_stall: got %0h want 0", cpu_stall); end
    nChecks++; if (mem_req !== 1'b0) begin nFails++; $display("[TB] FAIL write_req_done: got %0h want 0", mem_req); end
    nChecks++; if (cpu_rdata !== 32'h1234_5678) begin nFails++; $display("[TB] FAIL write_rdata_kept: got %h want 12345678", cpu_rdata); end
`ifdef DATA_MEM_BRIDGE_WBUF_EN
    nChecks++; if (stallCnt !== 0) begin nFails++; $display("[TB] FAIL write_stall_cycles: got %0d want 0", stallCnt); end
`else
    nChecks++; if (stallCnt !== 2) begin nFails++; $display("[TB] FAIL write_stall_cycles: got %0d want 2", stallCnt); end
`endif
    cpu_ena = 1'b0; cpu_wea = 4'h0;
    nextCycle();
  endtask

  // Read with no ack: mem_req is high for exactly 4 cycles, then the error
  // path completes. A late ack in IDLE must be ignored.
  task automatic test_timeout();
    int reqCnt;
    reqCnt = 0;
    cpu_ena = 1'b1; cpu_wea = 4'h0; cpu_addr = 32'h0000_0040;
    #1;
    nextCycle();
    for (int i = 0; i < 4; i++) begin
      #1;
      reqCnt += int'(mem_req);
      nChecks++; if (cpu_stall !== 1'b1) begin nFails++; $display("[TB] FAIL timeout_stall_wait%0d: got %0h want 1", i, cpu_stall); end
      nextCycle();
    end
    #1;
    nChecks++; if (mem_req !== 1'b0) begin nFails++; $display("[TB] FAIL timeout_req_dropped: got %0h want 0", mem_req); end
    nChecks++; if (reqCnt !== 4) begin nFails++; $display("[TB] FAIL timeout_req_cycles: got %0d want 4", reqCnt); end
    nChecks++; if (bus_err !== 1'b1) begin nFails++; $display("[TB] FAIL timeout_bus_err: got %0h want 1", bus_err); end
    nChecks++; if (cpu_rdata !== 32'hDEAD_BEEF) begin nFails++; $display("[TB] FAIL timeout_rdata: got %h want deadbeef", cpu_rdata); end
    nChecks++; if (cpu_stall !== 1'b0) begin nFails++; $display("[TB] FAIL timeout_done_stall: got %0h want 0", cpu_stall); end
    cpu_ena = 1'b0;
    nextCycle();
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    nextCycle();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    #1;
    nChecks++; if (cpu_rdata !== 32'hDEAD_BEEF) begin nFails++; $display("[TB] FAIL late_ack_rdata: got %h want deadbeef", cpu_rdata); end
    nChecks++; if (mem_req !== 1'b0) begin nFails++; $display("[TB] FAIL late_ack_req: got %0h want 0", mem_req); end
    nChecks++; if (cpu_stall !== 1'b0) begin nFails++; $display("[TB] FAIL late_ack_stall: got %0h want 0", cpu_stall); end
    nextCycle();
  endtask

  // Two reads with cpu_ena held high throughout: two distinct request
  // pulses, and no access is started during DONE.
  task automatic test_back_to_back();
    int pulses;
    logic prevReq;
    pulses = 0;
    prevReq = 1'b0;
    cpu_ena = 1'b1; cpu_wea = 4'h0; cpu_addr = 32'h0000_0100;
    #1;
    if (mem_req && !prevReq) pulses++;
    prevReq = mem_req;
    nextCycle();
    mem_ack = 1'b1; mem_rdata = 32'hA1A1_A1A1;
    #1;
    if (mem_req && !prevReq) pulses++;
    prevReq = mem_req;
    nextCycle();
    mem_ack = 1'b0;
    cpu_addr = 32'h0000_0104;
    #1;
    if (mem_req && !prevReq) pulses++;
    prevReq = mem_req;
    nChecks++; if (cpu_rdata !== 32'hA1A1_A1A1) begin nFails++; $display("[TB] FAIL b2b_rdata_first: got %h want a1a1a1a1", cpu_rdata); end
    nChecks++; if (cpu_stall !== 1'b0) begin nFails++; $display("[TB] FAIL b2b_done_stall: got %0h want 0", cpu_stall); end
    nextCycle();
    #1;
    if (mem_req && !prevReq) pulses++;
    prevReq = mem_req;
    nChecks++; if (mem_req !== 1'b0) begin nFails++; $display("[TB] FAIL b2b_no_req_after_done: got %0h want 0", mem_req); end
    nChecks++; if (cpu_stall !== 1'b1) begin nFails++; $display("[TB] FAIL b2b_second_accept_stall: got %0h want 1", cpu_stall); end
    nextCycle();
    mem_ack = 1'b1; mem_rdata = 32'hB2B2_B2B2;
    #1;
    if (mem_req && !prevReq) pulses++;
    prevReq = mem_req;
    nChecks++; if (mem_addr !== 32'h0000_0104) begin nFails++; $display("[TB] FAIL b2b_second_addr: got %h want 00000104", mem_addr); end
    nextCycle();
    mem_ack = 1'b0;
    #1;
    if (mem_req && !prevReq) pulses++;
    prevReq = mem_req;
    nChecks++; if (cpu_rdata !== 32'hB2B2_B2B2) begin nFails++; $display("[TB] FAIL b2b_rdata_second: got %h want b2b2b2b2", cpu_rdata); end
    nChecks++; if (bus_err !== 1'b1) begin nFails++; $display("[TB] FAIL b2b_bus_err_sticky: got %0h want 1", bus_err); end
    cpu_ena = 1'b0;
    nextCycle();
    #1;
    if (mem_req && !prevReq) pulses++;
    nChecks++; if (pulses !== 2) begin nFails++; $display("[TB] FAIL b2b_req_pulses: got %0d want 2", pulses); end
    nextCycle();
  endtask

  // Asynchronous reset while WAIT is holding mem_req high.
  task automatic test_reset_mid();
    cpu_ena = 1'b1; cpu_wea = 4'h0; cpu_addr = 32'h0000_0200;
    nextCycle();
    #1;
    nChecks++; if (mem_req !== 1'b1) begin nFails++; $display("[TB] FAIL rstmid_req_before: got %0h want 1", mem_req); end
    rst = 1'b0;
    #1;
    nChecks++; if (mem_req !== 1'b0) begin nFails++; $display("[TB] FAIL rstmid_req_async: got %0h want 0", mem_req); end
    nChecks++; if (bus_err !== 1'b0) begin nFails++; $display("[TB] FAIL rstmid_bus_err: got %0h want 0", bus_err); end
    nChecks++; if (cpu_rdata !== 32'd0) begin nFails++; $display("[TB] FAIL rstmid_rdata: got %h want 0", cpu_rdata); end
    cpu_ena = 1'b0;
    #1;
    nChecks++; if (cpu_stall !== 1'b0) begin nFails++; $display("[TB] FAIL rstmid_stall: got %0h want 0", cpu_stall); end
    @(negedge clk);
    rst = 1'b1;
    nextCycle();
    #1;
    nChecks++; if (cpu_stall !== 1'b0) begin nFails++; $display("[TB] FAIL rstmid_idle_stall: got %0h want 0", cpu_stall); end
    nChecks++; if (mem_req !== 1'b0) begin nFails++; $display("[TB] FAIL rstmid_idle_req: got %0h want 0", mem_req); end
    nextCycle();
  endtask

`ifdef DATA_MEM_BRIDGE_WBUF_EN
  // Posted write followed at once by a read. The slave acks 3 cycles after
  // mem_req. The read is held until the write finishes, then runs normally.
  task automatic test_posted_write();
    cpu_ena = 1'b1; cpu_wea = 4'hF; cpu_addr = 32'h0000_0300; cpu_wdata = 32'hCAFE_F00D;
    #1;
    nChecks++; if (cpu_stall !== 1'b0) begin nFails++; $display("[TB] FAIL wbuf_write_stall: got %0h want 0", cpu_stall); end
    nextCycle();
    cpu_wea = 4'h0; cpu_addr = 32'h0000_0304;
    #1;
    nChecks++; if (cpu_stall !== 1'b1) begin nFails++; $display("[TB] FAIL wbuf_read_held: got %0h want 1", cpu_stall); end
    nChecks++; if (mem_wr !== 1'b1) begin nFails++; $display("[TB] FAIL wbuf_write_wr: got %0h want 1", mem_wr); end
    nChecks++; if (mem_addr !== 32'h0000_0300) begin nFails++; $display("[TB] FAIL wbuf_write_addr: got %h want 00000300", mem_addr); end
    nextCycle();
    nextCycle();
    nextCycle();
    mem_ack = 1'b1;
    #1;
    nChecks++; if (cpu_stall !== 1'b1) begin nFails++; $display("[TB] FAIL wbuf_stall_at_ack: got %0h want 1", cpu_stall); end
    nextCycle();
    mem_ack = 1'b0;
    #1;
    nChecks++; if (mem_req !== 1'b0) begin nFails++; $display("[TB] FAIL wbuf_idle_req: got %0h want 0", mem_req); end
    nChecks++; if (cpu_stall !== 1'b1) begin nFails++; $display("[TB] FAIL wbuf_read_accept_stall: got %0h want 1", cpu_stall); end
    nextCycle();
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
    #1;
    nChecks++; if (mem_wr !== 1'b0) begin nFails++; $display("[TB] FAIL wbuf_read_wr: got %0h want 0", mem_wr); end
    nChecks++; if (mem_addr !== 32'h0000_0304) begin nFails++; $display("[TB] FAIL wbuf_read_addr: got %h want 00000304", mem_addr); end
    nextCycle();
    mem_ack = 1'b0;
    #1;
    nChecks++; if (cpu_stall !== 1'b0) begin nFails++; $display("[TB] FAIL wbuf_read_done_stall: got %0h want 0", cpu_stall); end
    nChecks++; if (cpu_rdata !== 32'h0BAD_F00D) begin nFails++; $display("[TB] FAIL wbuf_read_rdata: got %h want 0badf00d", cpu_rdata); end
    cpu_ena = 1'b0;
    nextCycle();
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
`ifdef DATA_MEM_BRIDGE_WBUF_EN
    test_posted_write();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
